mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 8:1 multiplexer path.
- Eight requesters each drive one data bit `i[k]`. The block grants the shared output line `y` to exactly one requester at a time and drives the mux select `sel` to match.
- Fairness is rotating priority; a programmable hold limit stops any one owner from starving the others.
- It sits between the requesting channels and the 8:1 mux datapath, and contains that mux internally.

---
 rtl/mux8_rr_arbiter_if.sv | 15 +
 rtl/mux8_rr_arbiter.sv | 63 ++++++
 tb/tb_mux8_rr_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: request/grant/data bundle between the channels and the 8:1 round-robin mux arbiter
// master: drives req, done, i; observes grant, sel, busy, timeout, y
// slave:  the arbiter; observes req, done, i; drives grant, sel, busy, timeout, y
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] i;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;
  logic       y;
  modport master (output req, done, i, input grant, sel, busy, timeout, y);
  modport slave (input req, done, i, output grant, sel, busy, timeout, y);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: rotating-priority arbiter with hold limit driving an internal 8:1 mux
// clk, rst      : rising-edge clock, synchronous active-high reset
// bus.req/done  : per-channel requests, owner release
// bus.i         : per-channel data bits
// bus.grant/sel : registered one-hot grant and matching mux select
// bus.busy      : registered, high while a grant is held
// bus.timeout   : registered one-cycle pulse on a hold-limit release
// bus.y         : combinational i[sel] while busy, else 0
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst,
  mux8_rr_arbiter_if.slave bus
);
  localparam logic [7:0] HOLD = 8'(MAX_HOLD);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [2:0] ptr, off, win;
  logic [7:0] cnt, rot;
  logic [15:0] dbl;
  logic lim, rel;
  // rotate requests so ptr sits at bit 0; the lowest set bit is then the winner offset
  always_comb begin
    dbl = {bus.req, bus.req};
    rot = dbl[ptr +: 8];
    off = 3'd0;
    for (int k = 7; k >= 0; k--) if (rot[k]) off = 3'(k);
    win = ptr + off;
    lim = cnt == HOLD;
    rel = bus.done | ~bus.req[bus.sel] | lim;
  end
  assign bus.y = bus.busy & bus.i[bus.sel];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.grant <= 8'd0;
      bus.sel <= 3'd0;
      bus.busy <= 1'b0;
      bus.timeout <= 1'b0;
      ptr <= 3'd0;
      cnt <= 8'd0;
    end else if (state == IDLE) begin
      bus.timeout <= 1'b0;
      if (|bus.req) begin
        state <= BUSY;
        bus.grant <= 8'd1 << win;
        bus.sel <= win;
        bus.busy <= 1'b1;
        cnt <= 8'd1;
      end
    end else if (rel) begin
      state <= IDLE;
      bus.grant <= 8'd0;
      bus.busy <= 1'b0;
      ptr <= bus.sel + 3'd1;
      bus.timeout <= lim & ~bus.done & bus.req[bus.sel];
    end else begin
      bus.timeout <= 1'b0;
      cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed plus random stimulus against a behavioural arbitration model
module tb_mux8_rr_arbiter;
  localparam int HOLD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  mux8_rr_arbiter_if bus ();
  mux8_rr_arbiter #(.MAX_HOLD(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit m_busy = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_held = 0;
  bit m_to = 0;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_all();
    chk("grant", bus.grant, m_busy ? 8'(1 << m_owner) : 8'h00);
    chk("sel", {5'd0, bus.sel}, 8'(m_owner));
    chk("busy", {7'd0, bus.busy}, {7'd0, m_busy});
    chk("timeout", {7'd0, bus.timeout}, {7'd0, m_to});
    chk("y", {7'd0, bus.y}, {7'd0, m_busy & bus.i[m_owner]});
    chk("onehot", {7'd0, $onehot0(bus.grant)}, 8'd1);
  endtask
  task automatic tick();
    bit found;
    bit rd, rw, rl;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      found = 0;
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (!found && bus.req[c]) begin
          found = 1;
          m_owner = c;
        end
      end
      if (found) begin
        m_busy = 1;
        m_held = 1;
      end
    end else begin
      rd = bus.done;
      rw = !bus.req[m_owner];
      rl = (m_held == HOLD);
      if (rd || rw || rl) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % 8;
        m_to = rl && !rd && !rw;
      end else begin
        m_held++;
        m_to = 0;
      end
    end
    @(posedge clk);
    #1;
    chk_all();
  endtask
  initial begin
    bus.req = 8'hFF; bus.done = 1'b0; bus.i = 8'hFF;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    rst = 1'b0;
    tick();
    chk("rst_release_grant", bus.grant, 8'h01);
    for (int g = 0; g < 9; g++) begin
      chk("rot_sel", {5'd0, bus.sel}, 8'(g % 8));
      chk("rot_busy1", {7'd0, bus.busy}, 8'd1);
      tick();
      chk("rot_busy2", {7'd0, bus.busy}, 8'd1);
      bus.done = 1'b1;
      tick();
      chk("rot_gap", {7'd0, bus.busy}, 8'd0);
      bus.done = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 8'h20;
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req = 8'b0010_0100;
    tick();
    chk("skip_grant", bus.grant, 8'h04);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    chk("skip_next", bus.grant, 8'h20);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req = 8'h00;
    tick();
    bus.req = 8'h08;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_busy", {7'd0, bus.busy}, 8'd1);
    end
    tick();
    chk("hold_timeout", {7'd0, bus.timeout}, 8'd1);
    chk("hold_idle", {7'd0, bus.busy}, 8'd0);
    tick();
    chk("hold_regrant", bus.grant, 8'h08);
    chk("hold_to_clear", {7'd0, bus.timeout}, 8'd0);
    tick();
    tick();
    tick();
    bus.done = 1'b1;
    tick();
    chk("hold_done_no_to", {7'd0, bus.timeout}, 8'd0);
    bus.done = 1'b0;
    bus.req = 8'h00;
    tick();
    bus.req = 8'h40;
    tick();
    bus.i = 8'h40;
    #1 chk("dp_y1", {7'd0, bus.y}, 8'd1);
    bus.i = 8'h00;
    #1 chk("dp_y0", {7'd0, bus.y}, 8'd0);
    bus.i = 8'h40;
    tick();
    bus.i = 8'h00;
    tick();
    bus.done = 1'b1;
    tick();
    bus.i = 8'hFF;
    #1 chk("dp_idle_y", {7'd0, bus.y}, 8'd0);
    bus.done = 1'b0;
    bus.req = 8'h00;
    tick();
    bus.req = 8'h02;
    tick();
    tick();
    tick();
    bus.req = 8'h00;
    tick();
    chk("wd_release", {7'd0, bus.busy}, 8'd0);
    chk("wd_no_to", {7'd0, bus.timeout}, 8'd0);
    bus.req = 8'h80;
    tick();
    chk("mr_grant7", bus.grant, 8'h80);
    rst = 1'b1;
    tick();
    chk("mr_grant0", bus.grant, 8'h00);
    rst = 1'b0;
    bus.req = 8'hFF;
    tick();
    chk("mr_ptr0", bus.grant, 8'h01);
    for (int n = 0; n < 400; n++) begin
      bus.req = 8'($urandom);
      bus.done = ($urandom_range(0, 3) == 0);
      bus.i = 8'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
